// File: rtl/fifo_line_reader_pkg.sv
// Shared definitions for the Sobel stream blocks: FSM state encoding and a
// width helper used to size line/row counters.
package fifo_line_reader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        BURST     = 2'd2,
        GAP       = 2'd3
    } state_t;

    // Bits needed to hold 0..v-1, never less than 1 so degenerate sizes still elaborate.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_line_reader_stream_out_reg.sv
// Output register for a valid/ready stream: loads on i_load, otherwise holds
// its contents until the consumer accepts.
module stream_out_reg #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fifo_line_reader.sv
// Drains a line FIFO one full image line at a time into a framed valid/ready
// pixel stream, inserting H_BLANK idle cycles after every line.
module fifo_line_reader
    import fifo_line_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned H_BLANK    = 16,
    parameter int unsigned CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic [CNT_WIDTH-1:0]  fifo_count,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  busy
);

    localparam int unsigned CW = clog2(IMG_WIDTH);
    localparam int unsigned RW = clog2(IMG_HEIGHT);
    localparam int unsigned GW = clog2(H_BLANK + 1);

    localparam logic [CW-1:0]        COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]        ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [GW-1:0]        GAP_LAST = GW'((H_BLANK == 0) ? 0 : H_BLANK - 1);
    localparam logic [CNT_WIDTH-1:0] LINE_CNT = CNT_WIDTH'(IMG_WIDTH);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [GW-1:0]   r_gap;
    logic            r_last_line;

    logic            w_pop;
    logic            w_line_done;
    logic            w_gap_done;
    logic            w_sof;
    logic            w_eol;
    logic            w_eof;
    logic [DATA_WIDTH+2:0] w_out;

    assign w_pop       = (r_state == BURST) & ~fifo_empty & (~out_valid | out_ready);
    assign w_line_done = w_pop & (r_col == COL_LAST);
    assign w_gap_done  = (r_gap == GAP_LAST);

    assign w_sof = (r_col == '0) & (r_row == '0);
    assign w_eol = (r_col == COL_LAST);
    assign w_eof = w_eol & (r_row == ROW_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (enable) w_next = WAIT_LINE;
            WAIT_LINE: if (fifo_count >= LINE_CNT) w_next = BURST;
            BURST: begin
                if (w_line_done) begin
                    if (H_BLANK != 0)            w_next = GAP;
                    else if (r_row == ROW_LAST)  w_next = IDLE;
                    else                         w_next = WAIT_LINE;
                end
            end
            GAP:       if (w_gap_done) w_next = r_last_line ? IDLE : WAIT_LINE;
            default:   w_next = IDLE;
        endcase
    end

    // Row advances at the last pop of a line; r_last_line remembers whether that
    // line closed the frame so GAP can pick IDLE vs WAIT_LINE after the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_gap       <= '0;
            r_last_line <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
            if (w_line_done) begin
                r_last_line <= (r_row == ROW_LAST);
                r_row       <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end
            if (r_state == GAP) r_gap <= w_gap_done ? '0 : r_gap + 1'b1;
            else                r_gap <= '0;
        end
    end

    stream_out_reg #(
        .WIDTH(DATA_WIDTH + 3)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_pop),
        .i_data  ({w_eof, w_eol, w_sof, fifo_dout}),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (w_out)
    );

    assign {out_eof, out_eol, out_sof, out_data} = w_out;
    assign fifo_rd_en = w_pop;
    assign busy       = (r_state != IDLE);

endmodule
